// File: rtl/mem_sched.sv
// Single-port memory scheduler: video, CPU and loader requesters plus periodic
// refresh share one SDRAM-controller front end under fixed priority.
module mem_sched #(
  parameter int AW   = 24,
  parameter int REFN = 392
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vReq,
  input  logic [AW-1:0] vA,
  output logic [7:0]    vQ,
  output logic          vValid,
  input  logic          cReq,
  input  logic          cWe,
  input  logic [AW-1:0] cA,
  input  logic [7:0]    cD,
  output logic [7:0]    cQ,
  output logic          cAck,
  input  logic          dReq,
  input  logic [AW-1:0] dA,
  input  logic [7:0]    dD,
  output logic          dAck,
  output logic          mReq,
  output logic          mRef,
  output logic          mWe,
  output logic [AW-1:0] mA,
  output logic [7:0]    mD,
  input  logic [7:0]    mQ,
  input  logic          mAck,
  output logic          ovr
);

  localparam int CW = (REFN > 1) ? $clog2(REFN) : 1;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {SRC_VID, SRC_REF, SRC_CPU, SRC_LDR} src_t;

  state_t        state, stateNext;
  src_t          owner, ownerNext;

  logic          vPend, rPend, cPend, dPend;
  logic [AW-1:0] vAddr, cAddr, dAddr;
  logic [7:0]    cData, dData;
  logic          cWrite;
  logic [CW-1:0] refCnt;

  logic          mReqNext, mRefNext, mWeNext;
  logic [AW-1:0] mANext;
  logic [7:0]    mDNext, vQNext, cQNext;
  logic          vValidNext, cAckNext, dAckNext;

  logic          done, vDone, rDone, cDone, dDone;
  logic          vCap, cCap, dCap, refTick;

  assign done    = (state == BUSY) && mAck;
  assign vDone   = done && (owner == SRC_VID);
  assign rDone   = done && (owner == SRC_REF);
  assign cDone   = done && (owner == SRC_CPU);
  assign dDone   = done && (owner == SRC_LDR);

  // A strobe is accepted when the slot is free or being freed on this same edge.
  assign vCap    = vReq && (!vPend || vDone);
  assign cCap    = cReq && (!cPend || cDone);
  assign dCap    = dReq && (!dPend || dDone);
  assign refTick = (refCnt == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vPend  <= 1'b0;
      rPend  <= 1'b0;
      cPend  <= 1'b0;
      dPend  <= 1'b0;
      vAddr  <= '0;
      cAddr  <= '0;
      dAddr  <= '0;
      cData  <= '0;
      dData  <= '0;
      cWrite <= 1'b0;
      refCnt <= CW'(REFN - 1);
      ovr    <= 1'b0;
    end else begin
      vPend <= (vPend && !vDone) || vCap;
      cPend <= (cPend && !cDone) || cCap;
      dPend <= (dPend && !dDone) || dCap;
      rPend <= (rPend && !rDone) || refTick;
      if (vCap) vAddr <= vA;
      if (cCap) begin
        cAddr  <= cA;
        cData  <= cD;
        cWrite <= cWe;
      end
      if (dCap) begin
        dAddr <= dA;
        dData <= dD;
      end
      refCnt <= refTick ? CW'(REFN - 1) : refCnt - 1'b1;
      // Overrun only if the previous refresh is still outstanding after this edge.
      if (refTick && rPend && !rDone) ovr <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      owner  <= SRC_VID;
      mReq   <= 1'b0;
      mRef   <= 1'b0;
      mWe    <= 1'b0;
      mA     <= '0;
      mD     <= '0;
      vQ     <= '0;
      cQ     <= '0;
      vValid <= 1'b0;
      cAck   <= 1'b0;
      dAck   <= 1'b0;
    end else begin
      state  <= stateNext;
      owner  <= ownerNext;
      mReq   <= mReqNext;
      mRef   <= mRefNext;
      mWe    <= mWeNext;
      mA     <= mANext;
      mD     <= mDNext;
      vQ     <= vQNext;
      cQ     <= cQNext;
      vValid <= vValidNext;
      cAck   <= cAckNext;
      dAck   <= dAckNext;
    end
  end

  always_comb begin
    stateNext  = state;
    ownerNext  = owner;
    mReqNext   = mReq;
    mRefNext   = mRef;
    mWeNext    = mWe;
    mANext     = mA;
    mDNext     = mD;
    vQNext     = vQ;
    cQNext     = cQ;
    vValidNext = 1'b0;
    cAckNext   = 1'b0;
    dAckNext   = 1'b0;
    case (state)
      IDLE: begin
        // Fixed priority: video > refresh > CPU > loader.
        if (vPend) begin
          ownerNext = SRC_VID;
          stateNext = BUSY;
          mReqNext  = 1'b1;
          mRefNext  = 1'b0;
          mWeNext   = 1'b0;
          mANext    = vAddr;
        end else if (rPend) begin
          ownerNext = SRC_REF;
          stateNext = BUSY;
          mReqNext  = 1'b1;
          mRefNext  = 1'b1;
          mWeNext   = 1'b0;
          mANext    = '0;
        end else if (cPend) begin
          ownerNext = SRC_CPU;
          stateNext = BUSY;
          mReqNext  = 1'b1;
          mRefNext  = 1'b0;
          mWeNext   = cWrite;
          mANext    = cAddr;
          mDNext    = cData;
        end else if (dPend) begin
          ownerNext = SRC_LDR;
          stateNext = BUSY;
          mReqNext  = 1'b1;
          mRefNext  = 1'b0;
          mWeNext   = 1'b1;
          mANext    = dAddr;
          mDNext    = dData;
        end
      end
      BUSY: begin
        if (mAck) begin
          stateNext = IDLE;
          mReqNext  = 1'b0;
          mRefNext  = 1'b0;
          case (owner)
            SRC_VID: begin
              vValidNext = 1'b1;
              vQNext     = mQ;
            end
            SRC_CPU: begin
              cAckNext = 1'b1;
              if (!mWe) cQNext = mQ;
            end
            SRC_LDR: dAckNext = 1'b1;
            default: ;
          endcase
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_sched.sv
// Directed self-checking bench for mem_sched, run with a short refresh period
// so that refresh spacing and overrun can be observed quickly.
module tb_mem_sched;

  localparam int AW = 24;

  logic          clock;
  logic          reset;
  logic          vReq, cReq, cWe, dReq, mAck;
  logic [AW-1:0] vA, cA, dA;
  logic [7:0]    cD, dD, mQ;
  logic [7:0]    vQ, cQ, mD;
  logic          vValid, cAck, dAck, mReq, mRef, mWe, ovr;
  logic [AW-1:0] mA;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  mem_sched #(.AW(AW), .REFN(16)) dut (
    .clock(clock), .reset(reset),
    .vReq(vReq), .vA(vA), .vQ(vQ), .vValid(vValid),
    .cReq(cReq), .cWe(cWe), .cA(cA), .cD(cD), .cQ(cQ), .cAck(cAck),
    .dReq(dReq), .dA(dA), .dD(dD), .dAck(dAck),
    .mReq(mReq), .mRef(mRef), .mWe(mWe), .mA(mA), .mD(mD),
    .mQ(mQ), .mAck(mAck), .ovr(ovr)
  );

  always #5 clock = ~clock;

  // Advance n rising edges and settle just past the last one.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    reset = 1'b0;
    vReq = 0; cReq = 0; cWe = 0; dReq = 0; mAck = 0;
    vA = '0; cA = '0; dA = '0; cD = '0; dD = '0; mQ = '0;
    applyStimulus(2);
    reset = 1'b1;
  endtask

  initial begin
    clock = 1'b0;
    resetDut();

    // Reset state
    checkOutput("rst_mReq", mReq, 0);
    checkOutput("rst_mA", mA, 0);
    checkOutput("rst_vValid", vValid, 0);
    checkOutput("rst_cQ", cQ, 0);
    checkOutput("rst_ovr", ovr, 0);

    // Single zero-wait video read
    vReq = 1; vA = 24'h012345;
    applyStimulus(1);
    vReq = 0;
    checkOutput("v1_mReq_n1", mReq, 0);
    applyStimulus(1);
    checkOutput("v1_mReq_n2", mReq, 1);
    checkOutput("v1_mA", mA, 32'h012345);
    checkOutput("v1_mWe", mWe, 0);
    checkOutput("v1_mRef", mRef, 0);
    checkOutput("v1_vValid_early", vValid, 0);
    mAck = 1; mQ = 8'hA5;
    applyStimulus(1);
    mAck = 0;
    checkOutput("v1_vValid", vValid, 1);
    checkOutput("v1_vQ", vQ, 8'hA5);
    checkOutput("v1_mReq_done", mReq, 0);
    applyStimulus(1);
    checkOutput("v1_vValid_late", vValid, 0);
    checkOutput("v1_mReq_idle", mReq, 0);

    // Simultaneous video, CPU write and loader write
    resetDut();
    vReq = 1; vA = 24'h000010;
    cReq = 1; cWe = 1; cA = 24'h004000; cD = 8'h3C;
    dReq = 1; dA = 24'h000100; dD = 8'h77;
    applyStimulus(1);
    vReq = 0; cReq = 0; dReq = 0;
    applyStimulus(1);
    checkOutput("arb_first_mA", mA, 32'h000010);
    checkOutput("arb_first_mWe", mWe, 0);
    mAck = 1; mQ = 8'h81;
    applyStimulus(1);
    mAck = 0;
    checkOutput("arb_vValid", vValid, 1);
    checkOutput("arb_cAck_early", cAck, 0);
    checkOutput("arb_gap", mReq, 0);
    applyStimulus(1);
    checkOutput("arb_cpu_mReq", mReq, 1);
    checkOutput("arb_cpu_mA", mA, 32'h004000);
    checkOutput("arb_cpu_mWe", mWe, 1);
    checkOutput("arb_cpu_mD", mD, 8'h3C);
    mAck = 1; mQ = 8'hEE;
    applyStimulus(1);
    mAck = 0;
    checkOutput("arb_cAck", cAck, 1);
    checkOutput("arb_cQ_kept", cQ, 0);
    checkOutput("arb_vValid_off", vValid, 0);
    applyStimulus(1);
    checkOutput("arb_ldr_mA", mA, 32'h000100);
    checkOutput("arb_ldr_mWe", mWe, 1);
    checkOutput("arb_ldr_mD", mD, 8'h77);
    mAck = 1;
    applyStimulus(1);
    mAck = 0;
    checkOutput("arb_dAck", dAck, 1);
    checkOutput("arb_cAck_off", cAck, 0);

    // CPU read with five wait cycles, video strobe arriving mid-access
    resetDut();
    cReq = 1; cWe = 0; cA = 24'h00ABCD;
    applyStimulus(1);
    cReq = 0;
    applyStimulus(1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("ws_mReq_held", mReq, 1);
      checkOutput("ws_mA_held", mA, 32'h00ABCD);
      checkOutput("ws_cAck_low", cAck, 0);
      if (i == 1) begin
        vReq = 1; vA = 24'h000777;
      end
      if (i == 5) begin
        mAck = 1; mQ = 8'h5A;
      end
      applyStimulus(1);
      vReq = 0;
    end
    mAck = 0;
    checkOutput("ws_cAck", cAck, 1);
    checkOutput("ws_cQ", cQ, 8'h5A);
    checkOutput("ws_no_preempt_vValid", vValid, 0);
    applyStimulus(1);
    checkOutput("ws_cAck_single", cAck, 0);
    checkOutput("ws_vid_mReq", mReq, 1);
    checkOutput("ws_vid_mA", mA, 32'h000777);
    mAck = 1; mQ = 8'h99;
    applyStimulus(1);
    mAck = 0;
    checkOutput("ws_vValid", vValid, 1);
    checkOutput("ws_vQ", vQ, 8'h99);

    // Repeated strobes while pending are ignored
    resetDut();
    vReq = 1; vA = 24'h000AAA;
    applyStimulus(1);
    vA = 24'h000BBB;
    applyStimulus(1);
    checkOutput("rep_mA", mA, 32'h000AAA);
    vA = 24'h000CCC;
    applyStimulus(1);
    vReq = 0;
    checkOutput("rep_mA_busy", mA, 32'h000AAA);
    mAck = 1; mQ = 8'h11;
    applyStimulus(1);
    mAck = 0;
    checkOutput("rep_vValid", vValid, 1);
    applyStimulus(1);
    checkOutput("rep_one_access_a", mReq, 0);
    applyStimulus(1);
    checkOutput("rep_one_access_b", mReq, 0);

    // Strobe on the completion edge: second access after a one-cycle gap
    vReq = 1; vA = 24'h000DDD;
    applyStimulus(1);
    vReq = 0;
    applyStimulus(1);
    checkOutput("ce_first_mA", mA, 32'h000DDD);
    mAck = 1; mQ = 8'h22; vReq = 1; vA = 24'h000EEE;
    applyStimulus(1);
    mAck = 0; vReq = 0;
    checkOutput("ce_vValid", vValid, 1);
    checkOutput("ce_gap", mReq, 0);
    applyStimulus(1);
    checkOutput("ce_second_mReq", mReq, 1);
    checkOutput("ce_second_mA", mA, 32'h000EEE);
    checkOutput("ce_vValid_off", vValid, 0);
    mAck = 1; mQ = 8'h33;
    applyStimulus(1);
    mAck = 0;
    checkOutput("ce_second_vQ", vQ, 8'h33);

    // Refresh every 16 cycles, then overrun while the second refresh stalls
    resetDut();
    applyStimulus(16);
    checkOutput("ref_quiet", mReq, 0);
    applyStimulus(1);
    checkOutput("ref1_mReq", mReq, 1);
    checkOutput("ref1_mRef", mRef, 1);
    checkOutput("ref1_mA", mA, 0);
    checkOutput("ref1_mWe", mWe, 0);
    mAck = 1;
    applyStimulus(1);
    mAck = 0;
    checkOutput("ref1_done_mReq", mReq, 0);
    checkOutput("ref1_done_mRef", mRef, 0);
    checkOutput("ref1_no_pulse", {vValid, cAck, dAck}, 0);
    applyStimulus(14);
    checkOutput("ref2_quiet", mReq, 0);
    applyStimulus(1);
    checkOutput("ref2_mReq", mReq, 1);
    checkOutput("ref2_mRef", mRef, 1);
    applyStimulus(14);
    checkOutput("ovr_before", ovr, 0);
    applyStimulus(1);
    checkOutput("ovr_set", ovr, 1);
    checkOutput("ovr_mReq_held", mReq, 1);
    applyStimulus(5);
    mAck = 1;
    applyStimulus(1);
    mAck = 0;
    checkOutput("ovr_ack_mReq", mReq, 0);
    checkOutput("ovr_ack_sticky", ovr, 1);
    applyStimulus(3);
    checkOutput("ovr_sticky", ovr, 1);

    // Reset asserted during an access
    resetDut();
    checkOutput("mr_ovr_cleared", ovr, 0);
    cReq = 1; cWe = 0; cA = 24'h000321;
    applyStimulus(1);
    cReq = 0;
    applyStimulus(1);
    checkOutput("mr_busy", mReq, 1);
    reset = 0;
    #1;
    checkOutput("mr_async_mReq", mReq, 0);
    checkOutput("mr_async_mA", mA, 0);
    mAck = 1; mQ = 8'h42;
    applyStimulus(1);
    reset = 1;
    applyStimulus(1);
    mAck = 0;
    checkOutput("mr_late_ack_cAck", cAck, 0);
    checkOutput("mr_late_ack_cQ", cQ, 0);
    checkOutput("mr_late_ack_mReq", mReq, 0);
    applyStimulus(2);
    checkOutput("mr_no_retry", mReq, 0);
    dReq = 1; dA = 24'h000123; dD = 8'h55;
    applyStimulus(1);
    dReq = 0;
    applyStimulus(1);
    checkOutput("mr_resume_mA", mA, 32'h000123);
    checkOutput("mr_resume_mD", mD, 8'h55);
    mAck = 1;
    applyStimulus(1);
    mAck = 0;
    checkOutput("mr_resume_dAck", dAck, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
